// File: rtl/switch_box_connector_cfg.sv
// switch_box_connector_cfg: joins two unequal routing channels through a serially configured crossbar
module switch_box_connector_cfg #(
    parameter int W0      = 5,
    parameter int W1      = 7,
    parameter bit REG_OUT = 1'b1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cfg_en,
    input  logic          cfg_in,
    input  logic          cfg_commit,
    output logic          cfg_out,
    input  logic [W0-1:0] data0_in,
    output logic [W0-1:0] data0_out,
    input  logic [W1-1:0] data1_in,
    output logic [W1-1:0] data1_out
);
    localparam int S0 = (W0 > 1) ? $clog2(W0) : 1;
    localparam int S1 = (W1 > 1) ? $clog2(W1) : 1;
    localparam int F0 = S0 + 1;
    localparam int F1 = S1 + 1;
    localparam int L  = W0 * F1 + W1 * F0;

    function automatic logic [L-1:0] modulo_map();
        logic [L-1:0] m;
        m = '0;
        for (int i = 0; i < W0; i++) m[i*F1 +: F1] = {1'b1, S1'(i % W1)};
        for (int j = 0; j < W1; j++) m[W0*F1 + j*F0 +: F0] = {1'b1, S0'(j % W0)};
        return m;
    endfunction

    localparam logic [L-1:0] DEFAULT_MAP = modulo_map();

    logic [L-1:0]  sh;
    logic [L-1:0]  ac;
    logic [W0-1:0] v0;
    logic [W1-1:0] v1;

    assign cfg_out = sh[L-1];

    // Shadow chain shifts freely; active map only changes on commit, taking the pre-shift shadow
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh <= DEFAULT_MAP;
            ac <= DEFAULT_MAP;
        end else begin
            if (cfg_en) sh <= {sh[L-2:0], cfg_in};
            if (cfg_commit) ac <= sh;
        end
    end

    // Route each output from its selected opposite-side track; disabled or out-of-range selects read 0
    always_comb begin
        v0 = '0;
        v1 = '0;
        for (int i = 0; i < W0; i++)
            for (int k = 0; k < W1; k++)
                v0[i] = (ac[i*F1 +: S1] == S1'(k)) ? (ac[i*F1 + S1] & data1_in[k]) : v0[i];
        for (int j = 0; j < W1; j++)
            for (int k = 0; k < W0; k++)
                v1[j] = (ac[W0*F1 + j*F0 +: S0] == S0'(k)) ? (ac[W0*F1 + j*F0 + S0] & data0_in[k]) : v1[j];
    end

    generate
        if (REG_OUT) begin : g_reg
            // Register the routed values; cleared while in reset
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    data0_out <= '0;
                    data1_out <= '0;
                end else begin
                    data0_out <= v0;
                    data1_out <= v1;
                end
            end
        end else begin : g_comb
            assign data0_out = v0;
            assign data1_out = v1;
        end
    endgenerate
endmodule
